mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-input, 32-bit datapath mux between 8 requesters.
- Produces the mux's 3-bit selector, plus a one-hot grant and a grant-valid qualifier.
- Enforces a bounded hold time so no requester starves the others.
- Inserts a one-cycle turnaround between owners so downstream registers never latch a mux output while the selector is changing.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 30 +++
 rtl/mux8_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter: state encoding,
// requester/selector sizing and a one-hot helper.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: returns the first set request bit found when
// scanning from rr_ptr upward, wrapping modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SEL_W-1:0]   index
);

  logic [SEL_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = '0;
    // Walk from lowest to highest priority so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + SEL_W'(k);
      if (req[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for a shared 8:1 x 32-bit mux, with a bounded
// hold time, optional lock, and a one-cycle turnaround between owners.
module mux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic [SEL_W-1:0]   selector,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               preempt
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               preempt_q, preempt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gv_q, gv_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] others;
  logic               at_max;

  rr_pick8 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign others = req & ~onehot(owner_q);
  assign at_max = (hold_cnt_q == CNT_W'(MAX_HOLD));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
      grant_q    <= '0;
      sel_q      <= '0;
      gv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      gv_q       <= gv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          hold_cnt_d = CNT_W'(1);
          state_d    = ST_GRANT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A voluntary release takes precedence over the hold limit.
        if (!req[owner_q]) begin
          rr_ptr_d = owner_q + SEL_W'(1);
          state_d  = (|others) ? ST_TURN : ST_IDLE;
        end else if (at_max && (|others) && !lock) begin
          rr_ptr_d  = owner_q + SEL_W'(1);
          preempt_d = 1'b1;
          state_d   = ST_TURN;
        end else if (!at_max) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state; the selector only moves when
  // a new grant starts, so it is stable through IDLE and TURN.
  always_comb begin
    grant_d = '0;
    gv_d    = 1'b0;
    sel_d   = sel_q;
    if (state_d == ST_GRANT) begin
      grant_d = onehot(owner_d);
      gv_d    = 1'b1;
      sel_d   = owner_d;
    end
  end

  assign selector    = sel_q;
  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, single owner, hold-limit
// preemption, wrap-around, lock and release/limit collision.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       lock;
  logic [2:0] selector;
  logic [7:0] grant;
  logic       grant_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .selector    (selector),
    .grant       (grant),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_grant,
                       input logic [2:0] exp_sel, input logic exp_gv,
                       input logic exp_pre);
    checks++;
    assert ({grant, selector, grant_valid, preempt} ===
            {exp_grant, exp_sel, exp_gv, exp_pre})
    else begin
      errors++;
      $error("FAIL %s: observed grant=%h sel=%0d gv=%b pre=%b, expected grant=%h sel=%0d gv=%b pre=%b",
             tag, grant, selector, grant_valid, preempt,
             exp_grant, exp_sel, exp_gv, exp_pre);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset with all requests pending.
    reset = 1'b0;
    req   = 8'hFF;
    lock  = 1'b0;
    #3;
    check("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_release", 8'h01, 3'd0, 1'b1, 1'b0);

    // Single requester is never preempted; drop returns to IDLE, selector held.
    do_reset();
    req = 8'h20;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("single_hold", 8'h20, 3'd5, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    check("single_drop", 8'h00, 3'd5, 1'b0, 1'b0);

    // Reset asserted mid-grant clears outputs immediately.
    req = 8'h20;
    tick();
    check("midrst_pre", 8'h20, 3'd5, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;

    // Preemption ping-pong between requesters 0 and 7.
    do_reset();
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pre_own0", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    check("pre_turn0", 8'h00, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pre_own7", 8'h80, 3'd7, 1'b1, 1'b0);
    end
    tick();
    check("pre_turn7", 8'h00, 3'd7, 1'b0, 1'b1);
    tick();
    check("pre_back0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Owner 7 releases; pointer wraps to 0.
    do_reset();
    req = 8'h80;
    tick();
    check("wrap_own7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h03;
    tick();
    check("wrap_turn", 8'h00, 3'd7, 1'b0, 1'b0);
    tick();
    check("wrap_own0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Lock keeps requester 1 beyond the hold limit.
    do_reset();
    req  = 8'h06;
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lock_hold", 8'h02, 3'd1, 1'b1, 1'b0);
    end
    lock = 1'b0;
    tick();
    check("lock_turn", 8'h00, 3'd1, 1'b0, 1'b1);
    tick();
    check("lock_next", 8'h04, 3'd2, 1'b1, 1'b0);

    // Release coincides with hold limit: no preempt, pointer still advances.
    do_reset();
    req = 8'h03;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("coll_own0", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    req = 8'h02;
    tick();
    check("coll_turn", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h03;
    tick();
    check("coll_rrptr", 8'h02, 3'd1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
